// File: rtl/id_ex_stage_pkg.sv
// Shared RISC-V core definitions used by the ID/EX stage.
// Contents:
//   - default datapath widths
//   - ALU operation codes
//   - forwarding-source select encoding
package riscv_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_OR  = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SLT = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus bundle around the ID/EX stage.
// Groups the decode-side inputs, the MEM/WB forwarding sources, the
// hazard controls (stall/flush) and the EX-side outputs.
//   slave  : view of the ID/EX stage itself
//   master : view of the surrounding pipeline (or a testbench)
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      stall;
  logic                      flush;

  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic [3:0]                id_alu_control;
  logic                      id_alu_src_imm;
  logic                      id_reg_write;

  logic                      mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0]     mem_result;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic [DATA_WIDTH-1:0]     wb_result;

  logic [3:0]                ex_alu_control;
  logic [DATA_WIDTH-1:0]     ex_alu_a;
  logic [DATA_WIDTH-1:0]     ex_alu_b;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_write;
  logic                      ex_valid;
  logic [1:0]                ex_fwd_a;
  logic [1:0]                ex_fwd_b;

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1_addr, id_rs2_addr, id_rd_addr,
    input  id_alu_control, id_alu_src_imm, id_reg_write,
    input  mem_reg_write, mem_rd_addr, mem_result,
    input  wb_reg_write, wb_rd_addr, wb_result,
    output ex_alu_control, ex_alu_a, ex_alu_b, ex_store_data,
    output ex_rd_addr, ex_reg_write, ex_valid, ex_fwd_a, ex_fwd_b
  );

  modport master (
    output stall, flush,
    output id_valid, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1_addr, id_rs2_addr, id_rd_addr,
    output id_alu_control, id_alu_src_imm, id_reg_write,
    output mem_reg_write, mem_rd_addr, mem_result,
    output wb_reg_write, wb_rd_addr, wb_result,
    input  ex_alu_control, ex_alu_a, ex_alu_b, ex_store_data,
    input  ex_rd_addr, ex_reg_write, ex_valid, ex_fwd_a, ex_fwd_b
  );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: combinational forwarding-source selection for both
// ALU source operands.
// Ports:
//   rs1_addr, rs2_addr         registered source register indices
//   mem_reg_write, mem_rd_addr EX/MEM writer
//   wb_reg_write,  wb_rd_addr  MEM/WB writer
//   fwd_a, fwd_b               selected source for rs1 / rs2
module forward_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output fwd_sel_e                  fwd_a,
  output fwd_sel_e                  fwd_b
);

  // The younger MEM result beats WB; x0 is hard-wired zero and never forwarded.
  function automatic fwd_sel_e pick_source(input logic [REG_ADDR_WIDTH-1:0] src);
    fwd_sel_e sel;
    if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // Source selection for both operands.
  always_comb begin
    fwd_a = pick_source(rs1_addr);
    fwd_b = pick_source(rs2_addr);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every stage register
//   bus    id_ex_stage_if.slave: stall/flush, id_* decode inputs,
//          mem_*/wb_* forwarding sources, ex_* ALU-facing outputs
// Register update priority: reset > flush > stall > load. A decode
// input with id_valid=0 is captured as a bubble, same as a flush.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  logic                      valid_r;
  logic [DATA_WIDTH-1:0]     rs1_data_r;
  logic [DATA_WIDTH-1:0]     rs2_data_r;
  logic [DATA_WIDTH-1:0]     imm_r;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_r;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_r;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
  logic [3:0]                alu_control_r;
  logic                      alu_src_imm_r;
  logic                      reg_write_r;

  fwd_sel_e                  fwd_a_s;
  fwd_sel_e                  fwd_b_s;
  logic [DATA_WIDTH-1:0]     rs1_fwd_s;
  logic [DATA_WIDTH-1:0]     rs2_fwd_s;

  // Stage register: reset and bubble both clear every field (bubble ALU op is ADD = 0).
  always_ff @(posedge clk) begin
    if (reset || bus.flush || (!bus.stall && !bus.id_valid)) begin
      valid_r       <= 1'b0;
      rs1_data_r    <= '0;
      rs2_data_r    <= '0;
      imm_r         <= '0;
      rs1_addr_r    <= '0;
      rs2_addr_r    <= '0;
      rd_addr_r     <= '0;
      alu_control_r <= ALU_ADD;
      alu_src_imm_r <= 1'b0;
      reg_write_r   <= 1'b0;
    end else if (!bus.stall) begin
      valid_r       <= 1'b1;
      rs1_data_r    <= bus.id_rs1_data;
      rs2_data_r    <= bus.id_rs2_data;
      imm_r         <= bus.id_imm;
      rs1_addr_r    <= bus.id_rs1_addr;
      rs2_addr_r    <= bus.id_rs2_addr;
      rd_addr_r     <= bus.id_rd_addr;
      alu_control_r <= bus.id_alu_control;
      alu_src_imm_r <= bus.id_alu_src_imm;
      reg_write_r   <= bus.id_reg_write;
    end else begin
      valid_r       <= valid_r;
      rs1_data_r    <= rs1_data_r;
      rs2_data_r    <= rs2_data_r;
      imm_r         <= imm_r;
      rs1_addr_r    <= rs1_addr_r;
      rs2_addr_r    <= rs2_addr_r;
      rd_addr_r     <= rd_addr_r;
      alu_control_r <= alu_control_r;
      alu_src_imm_r <= alu_src_imm_r;
      reg_write_r   <= reg_write_r;
    end
  end

  forward_unit #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_forward_unit (
    .rs1_addr      (rs1_addr_r),
    .rs2_addr      (rs2_addr_r),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .fwd_a         (fwd_a_s),
    .fwd_b         (fwd_b_s)
  );

  // Forwarding muxes; kept combinational so a stalled instruction sees results retiring now.
  always_comb begin
    rs1_fwd_s = rs1_data_r;
    rs2_fwd_s = rs2_data_r;
    case (fwd_a_s)
      FWD_MEM: rs1_fwd_s = bus.mem_result;
      FWD_WB:  rs1_fwd_s = bus.wb_result;
      default: rs1_fwd_s = rs1_data_r;
    endcase
    case (fwd_b_s)
      FWD_MEM: rs2_fwd_s = bus.mem_result;
      FWD_WB:  rs2_fwd_s = bus.wb_result;
      default: rs2_fwd_s = rs2_data_r;
    endcase
  end

  // Operand selection and EX-side outputs; store data always takes forwarded rs2.
  always_comb begin
    bus.ex_alu_a       = rs1_fwd_s;
    bus.ex_store_data  = rs2_fwd_s;
    if (alu_src_imm_r) begin
      bus.ex_alu_b     = imm_r;
    end else begin
      bus.ex_alu_b     = rs2_fwd_s;
    end
    bus.ex_alu_control = alu_control_r;
    bus.ex_rd_addr     = rd_addr_r;
    bus.ex_reg_write   = reg_write_r;
    bus.ex_valid       = valid_r;
    bus.ex_fwd_a       = fwd_a_s;
    bus.ex_fwd_b       = fwd_b_s;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [3:0] ctl, input logic simm,
                          input logic rw);
    bus.id_valid       = v;
    bus.id_rs1_data    = d1;
    bus.id_rs2_data    = d2;
    bus.id_imm         = imm;
    bus.id_rs1_addr    = a1;
    bus.id_rs2_addr    = a2;
    bus.id_rd_addr     = rd;
    bus.id_alu_control = ctl;
    bus.id_alu_src_imm = simm;
    bus.id_reg_write   = rw;
  endtask

  task automatic drive_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    bus.mem_reg_write = mw;
    bus.mem_rd_addr   = mrd;
    bus.mem_result    = mres;
    bus.wb_reg_write  = ww;
    bus.wb_rd_addr    = wrd;
    bus.wb_result     = wres;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    drive_id(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 5'd9, 5'd10, 5'd11,
             4'b0101, 1'b0, 1'b1);
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset with nonzero decode inputs
    step();
    step();
    check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
    check("rst_ctl",   {28'd0, bus.ex_alu_control}, 32'd0);
    check("rst_rd",    {27'd0, bus.ex_rd_addr}, 32'd0);
    check("rst_a",     bus.ex_alu_a, 32'd0);
    check("rst_b",     bus.ex_alu_b, 32'd0);
    check("rst_st",    bus.ex_store_data, 32'd0);
    check("rst_fwda",  {30'd0, bus.ex_fwd_a}, 32'd0);
    check("rst_fwdb",  {30'd0, bus.ex_fwd_b}, 32'd0);

    // Plain load, forwarding sources target other registers
    reset = 1'b0;
    drive_id(1'b1, 32'd5, 32'd7, 32'h100, 5'd1, 5'd2, 5'd4, 4'b0001, 1'b0, 1'b1);
    drive_fwd(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h10);
    step();
    check("ld_a",     bus.ex_alu_a, 32'd5);
    check("ld_b",     bus.ex_alu_b, 32'd7);
    check("ld_st",    bus.ex_store_data, 32'd7);
    check("ld_fwda",  {30'd0, bus.ex_fwd_a}, 32'd0);
    check("ld_fwdb",  {30'd0, bus.ex_fwd_b}, 32'd0);
    check("ld_ctl",   {28'd0, bus.ex_alu_control}, 32'd1);
    check("ld_rd",    {27'd0, bus.ex_rd_addr}, 32'd4);
    check("ld_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("ld_rw",    {31'd0, bus.ex_reg_write}, 32'd1);

    // MEM forwarding onto rs2 (x2), same cycle
    drive_fwd(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'h0);
    #1;
    check("memb_b",    bus.ex_alu_b, 32'h77);
    check("memb_st",   bus.ex_store_data, 32'h77);
    check("memb_fwdb", {30'd0, bus.ex_fwd_b}, 32'd1);

    // MEM beats WB on rs1 = x3
    drive_id(1'b1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd5, 5'd6, 4'b0000, 1'b0, 1'b1);
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    drive_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    #1;
    check("pri_a",    bus.ex_alu_a, 32'hAA);
    check("pri_fwda", {30'd0, bus.ex_fwd_a}, 32'd1);
    bus.mem_reg_write = 1'b0;
    #1;
    check("wb_a",     bus.ex_alu_a, 32'hBB);
    check("wb_fwda",  {30'd0, bus.ex_fwd_a}, 32'd2);
    bus.wb_reg_write = 1'b0;
    #1;
    check("none_a",   bus.ex_alu_a, 32'h11);
    check("none_fwda", {30'd0, bus.ex_fwd_a}, 32'd0);

    // x0 never forwarded; immediate drives B
    drive_id(1'b1, 32'h1, 32'h0, 32'hFFFF_FFF0, 5'd1, 5'd0, 5'd2, 4'b0110, 1'b1, 1'b1);
    drive_fwd(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
    step();
    check("x0_st",   bus.ex_store_data, 32'd0);
    check("x0_fwdb", {30'd0, bus.ex_fwd_b}, 32'd0);
    check("imm_b",   bus.ex_alu_b, 32'hFFFF_FFF0);

    // Stall for three cycles while decode inputs change
    drive_id(1'b1, 32'h33, 32'h44, 32'h0, 5'd6, 5'd7, 5'd8, 4'b0101, 1'b0, 1'b1);
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'h900 + i, 32'h800 + i, 32'h700, 5'd20 + 5'(i), 5'd21, 5'd22,
               4'b1000, 1'b1, 1'b0);
      step();
      check("stl_rd",  {27'd0, bus.ex_rd_addr}, 32'd8);
      check("stl_ctl", {28'd0, bus.ex_alu_control}, 32'd5);
      check("stl_b",   bus.ex_alu_b, 32'h44);
      if (i == 1) begin
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h12);
        #1;
        check("stl_wb_a",    bus.ex_alu_a, 32'h12);
        check("stl_wb_fwda", {30'd0, bus.ex_fwd_a}, 32'd2);
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      end else begin
        check("stl_a", bus.ex_alu_a, 32'h33);
      end
    end

    // Flush overrides simultaneous stall
    bus.flush = 1'b1;
    drive_id(1'b1, 32'h55, 32'h66, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0011, 1'b0, 1'b1);
    step();
    check("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("fl_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
    check("fl_ctl",   {28'd0, bus.ex_alu_control}, 32'd0);
    check("fl_rd",    {27'd0, bus.ex_rd_addr}, 32'd0);
    check("fl_a",     bus.ex_alu_a, 32'd0);

    // id_valid=0 is captured as a bubble
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive_id(1'b0, 32'h55, 32'h66, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0011, 1'b0, 1'b1);
    step();
    check("bub_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("bub_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
    check("bub_ctl",   {28'd0, bus.ex_alu_control}, 32'd0);
    check("bub_b",     bus.ex_alu_b, 32'd0);

    // Reset during a stall empties the stage
    drive_id(1'b1, 32'h55, 32'h66, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0011, 1'b0, 1'b1);
    step();
    check("pre_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.stall = 1'b1;
    reset     = 1'b1;
    step();
    check("rst_stl_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_stl_a",     bus.ex_alu_a, 32'd0);
    reset     = 1'b0;
    bus.stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RISC-V core. It registers decoded operands and control from the decode stage, and it resolves data hazards by forwarding from the MEM and WB stages. It drives the ALU's `Control`, `A` and `B` inputs directly. It also supports stall (hold) and flush (bubble insertion) requested by the hazard logic.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `REG_ADDR_WIDTH`, 5: register-file address width.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: hold all stage registers unchanged.
- `flush`  in  1: load a bubble instead of the decode inputs.
- `id_valid`  in  1: decode stage holds a real instruction.
- `id_rs1_data`, `id_rs2_data`, `id_imm`  in  DATA_WIDTH: register-file reads and the sign-extended immediate.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  REG_ADDR_WIDTH: source and destination register indices.
- `id_alu_control`  in  4: ALU operation code.
- `id_alu_src_imm`  in  1: B operand comes from the immediate, not from rs2.
- `id_reg_write`  in  1: the instruction writes rd.
- `mem_reg_write`  in  1, `mem_rd_addr`  in  REG_ADDR_WIDTH, `mem_result`  in  DATA_WIDTH: EX/MEM forwarding source.
- `wb_reg_write`  in  1, `wb_rd_addr`  in  REG_ADDR_WIDTH, `wb_result`  in  DATA_WIDTH: MEM/WB forwarding source.
- `ex_alu_control`  out  4: connects to the ALU `Control` input.
- `ex_alu_a`, `ex_alu_b`  out  DATA_WIDTH: connect to the ALU `A` and `B` inputs.
- `ex_store_data`  out  DATA_WIDTH: forwarded rs2 value, used for stores.
- `ex_rd_addr`  out  REG_ADDR_WIDTH; `ex_reg_write`  out  1; `ex_valid`  out  1.
- `ex_fwd_a`, `ex_fwd_b`  out  2: selected forwarding source (for debug and verification).

## Operation
- **Stage registers:** valid, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_control, alu_src_imm, reg_write.
- **Update priority per edge:** reset > flush > stall > load.
  - Reset: every register is cleared to 0.
  - Flush: load a bubble. Valid=0, reg_write=0, alu_control=ADD (4'b0000), all data and address fields 0. Flush overrides a simultaneous stall.
  - Stall: every register keeps its value.
  - Load: capture all `id_*` inputs. The `id_valid`=0 case is captured as a bubble.
- **Forwarding for rs1 (`ex_fwd_a`) and rs2 (`ex_fwd_b`), evaluated combinationally from the registered addresses:**
  - MEM: `mem_reg_write`=1, `mem_rd_addr`≠0 and `mem_rd_addr` equals the source address → take `mem_result`.
  - else WB: the same conditions on the WB port → take `wb_result`.
  - else NONE: take the registered register-file data.
  - MEM always wins over WB. Register x0 is never forwarded.
- **Operand muxes:**
  - `ex_alu_a` = forwarded rs1.
  - `ex_alu_b` = the registered imm if alu_src_imm=1, else the forwarded rs2.
  - `ex_store_data` = the forwarded rs2 in both cases.
- **Control outputs:** `ex_alu_control`, `ex_rd_addr`, `ex_reg_write` and `ex_valid` come directly from the registers.
- **Bubble behaviour:** a bubble still forwards normally, which is harmless because reg_write=0 downstream.
- **Width rule:** no arithmetic is done here. All data paths are pass-through at DATA_WIDTH.

## Timing
- **Latency:** 1 cycle from the `id_*` inputs to the `ex_*` outputs.
- **Forwarding path:** combinational from the `mem_*`/`wb_*` inputs to `ex_alu_a`, `ex_alu_b` and `ex_store_data` in the same cycle, with no registering.
- **Reset outputs:** all `ex_*` outputs are 0, `ex_alu_control`=4'b0000, and `ex_fwd_a`=`ex_fwd_b`=NONE. Any forwarding inputs still present during reset are ignored only because the addresses are 0 (x0).
- **Stall:** outputs keep the same registered fields, while the forwarded operands are re-evaluated each cycle. A stalled instruction therefore picks up results that retire during the stall.
- **Reset mid-stall or mid-flush:** reset wins, and the stage is empty on the next cycle.

## Structure
- **Shared package `riscv_pkg`:**
  - ALU control codes: ADD 0000, SUB 0001, MUL 0010, AND 0011, OR 0100, XOR 0101, SLL 0110, SRL 0111, SLT 1000.
  - Forwarding select encoding: NONE 2'b00, MEM 2'b01, WB 2'b10.
  - `DATA_WIDTH` and `REG_ADDR_WIDTH` defaults.
- **Sub-module `forward_unit`:** purely combinational. It is instantiated once with both source addresses and produces `ex_fwd_a` and `ex_fwd_b`. The stage register and the operand muxes stay in `id_ex_stage`.

## Test plan
- **Reset:** assert `reset` with all `id_*` inputs nonzero → the next cycle has all outputs 0 and `ex_alu_control`=0000.
- **Plain load:**
  - Stimulus: rs1_data=5, rs2_data=7, alu_control=0001, alu_src_imm=0, no matching forwarding.
  - Required response one cycle later: `ex_alu_a`=5, `ex_alu_b`=7, `ex_fwd_a`=`ex_fwd_b`=NONE.
- **MEM/WB priority:**
  - Stimulus: registered rs1_addr=3; mem_rd=3 with mem_result=0xAA and reg_write=1; wb_rd=3 with wb_result=0xBB and reg_write=1.
  - Required response: `ex_alu_a`=0xAA, `ex_fwd_a`=MEM. Dropping `mem_reg_write` then gives `ex_alu_a`=0xBB, `ex_fwd_a`=WB.
- **x0 and immediate:**
  - Stimulus: rs2_addr=0, mem_rd=0 with mem_result=0xFF, rs2_data=0.
  - Required response: `ex_store_data`=0, `ex_fwd_b`=NONE.
  - With alu_src_imm=1 and imm=0xFFFFFFF0: `ex_alu_b`=0xFFFFFFF0.
- **Stall:**
  - Stimulus: hold `stall` for 3 cycles while the `id_*` inputs change.
  - Required response: registered fields are unchanged throughout. A wb_result=0x12 matching rs1 that appears during the stall is reflected on `ex_alu_a` in the same cycle.
- **Flush:**
  - Stimulus: assert `flush` and `stall` together with a valid instruction.
  - Required response: the next cycle shows `ex_valid`=0, `ex_reg_write`=0, `ex_alu_control`=0000.
